// File: rtl/pll_pkg.sv
// Shared definitions for the digital PLL blocks.
// Holds the default DCO divider and pending-counter width, a period-length selector type,
// and the saturation-limit helper used by the signed pending-correction counter.
package pll_pkg;

  localparam int unsigned DefaultDivider   = 16;
  localparam int unsigned DefaultPendWidth = 4;

  // Length chosen for the period that is about to start.
  typedef enum logic [1:0] {
    LenNominal,
    LenShort,
    LenLong
  } len_sel_e;

  // Symmetric saturation bound of a signed counter: +/-(2^(width-1)-1).
  // The most negative code is never used, so advance and retard have equal range.
  function automatic int sat_limit(input int unsigned width);
    return (1 << (width - 1)) - 1;
  endfunction

endpackage

// File: rtl/pending_accumulator.sv
// Saturating signed up/down counter of corrections that have been requested but not yet
// applied to the DCO period.
// Ports:
//   clk_i, reset_i  clock and asynchronous active-low reset
//   carry_i         +1 request (advance)
//   borrow_i        -1 request (retard)
//   advance_i       a shortened period was just chosen, so one +1 has been applied
//   retard_i        a lengthened period was just chosen, so one -1 has been applied
//   pending_o       signed count still outstanding
module pending_accumulator
  import pll_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultPendWidth
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    carry_i,
  input  logic                    borrow_i,
  input  logic                    advance_i,
  input  logic                    retard_i,
  output logic signed [WIDTH-1:0] pending_o
);

  localparam int Limit = sat_limit(WIDTH);

  logic signed [WIDTH-1:0] pending_q, pending_d;
  int sum;

  // Requests and the correction applied this edge merge into a single update, so a
  // request in the terminal cycle lands after that cycle's evaluation.
  always_comb begin
    sum = int'(pending_q);
    if (carry_i)   sum = sum + 1;
    if (borrow_i)  sum = sum - 1;
    if (advance_i) sum = sum - 1;
    if (retard_i)  sum = sum + 1;
    if (sum > Limit) begin
      sum = Limit;
    end else if (sum < -Limit) begin
      sum = -Limit;
    end
    pending_d = WIDTH'(sum);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/id_pulse_modulator.sv
// Increment/decrement pulse modulator (DCO) of a digital PLL.
// Divides clk_i by DIVIDER, shortening a period by one cycle per outstanding advance and
// lengthening it by one cycle per outstanding retard. High time is fixed at DIVIDER/2.
// Ports:
//   clk_i, reset_i  clock and asynchronous active-low reset
//   carry_i         one-cycle advance request
//   borrow_i        one-cycle retard request
//   clk_o           registered divided clock
//   periodStart_o   strobe in the first cycle of each period (clk_o rising)
//   advanced_o      with periodStart_o: this period is DIVIDER-1 long
//   retarded_o      with periodStart_o: this period is DIVIDER+1 long
//   pending_o       signed count of corrections not yet applied
module id_pulse_modulator
  import pll_pkg::*;
#(
  parameter int unsigned DIVIDER    = DefaultDivider,
  parameter int unsigned PEND_WIDTH = DefaultPendWidth
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         carry_i,
  input  logic                         borrow_i,
  output logic                         clk_o,
  output logic                         periodStart_o,
  output logic                         advanced_o,
  output logic                         retarded_o,
  output logic signed [PEND_WIDTH-1:0] pending_o
);

  // Wide enough for the longest period length, DIVIDER+1.
  localparam int unsigned PW = $clog2(DIVIDER + 2);

  logic [PW-1:0] phase_q, phase_d;
  logic [PW-1:0] len_q, len_d;
  logic          clk_q, clk_d;
  logic          start_q, adv_q, ret_q;
  logic          terminal;
  len_sel_e      len_sel;
  logic signed [PEND_WIDTH-1:0] pending;

  pending_accumulator #(
    .WIDTH(PEND_WIDTH)
  ) u_pending (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .carry_i  (carry_i),
    .borrow_i (borrow_i),
    .advance_i(len_sel == LenShort),
    .retard_i (len_sel == LenLong),
    .pending_o(pending)
  );

  always_comb begin
    terminal = (phase_q == len_q - PW'(1));
    len_sel  = LenNominal;
    if (terminal) begin
      if (pending[PEND_WIDTH-1]) begin
        len_sel = LenLong;
      end else if (pending != '0) begin
        len_sel = LenShort;
      end
    end

    phase_d = terminal ? '0 : phase_q + PW'(1);

    len_d = len_q;
    if (terminal) begin
      unique case (len_sel)
        LenShort: len_d = PW'(DIVIDER - 1);
        LenLong:  len_d = PW'(DIVIDER + 1);
        default:  len_d = PW'(DIVIDER);
      endcase
    end

    // Only the low time stretches or shrinks, since the fall is fixed at phase DIVIDER/2.
    clk_d = clk_q;
    if (terminal) begin
      clk_d = 1'b1;
    end else if (phase_d == PW'(DIVIDER / 2)) begin
      clk_d = 1'b0;
    end
  end

  // Reset parks the phase in the terminal cycle so the first edge starts a fresh period.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      phase_q <= PW'(DIVIDER - 1);
      len_q   <= PW'(DIVIDER);
      clk_q   <= 1'b0;
      start_q <= 1'b0;
      adv_q   <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      len_q   <= len_d;
      clk_q   <= clk_d;
      start_q <= terminal;
      adv_q   <= (len_sel == LenShort);
      ret_q   <= (len_sel == LenLong);
    end
  end

  assign clk_o         = clk_q;
  assign periodStart_o = start_q;
  assign advanced_o    = adv_q;
  assign retarded_o    = ret_q;
  assign pending_o     = pending;

endmodule

// File: tb/tb_id_pulse_modulator.sv
module tb_id_pulse_modulator;

  logic              clk_i;
  logic              reset_i;
  logic              carry_i;
  logic              borrow_i;
  logic              clk_o;
  logic              periodStart_o;
  logic              advanced_o;
  logic              retarded_o;
  logic signed [3:0] pending_o;

  int checks = 0;
  int errors = 0;

  id_pulse_modulator #(
    .DIVIDER   (16),
    .PEND_WIDTH(4)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .carry_i      (carry_i),
    .borrow_i     (borrow_i),
    .clk_o        (clk_o),
    .periodStart_o(periodStart_o),
    .advanced_o   (advanced_o),
    .retarded_o   (retarded_o),
    .pending_o    (pending_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string name;
    bit    carry;
    bit    borrow;
    int    start;     // phase of period 0 at which requests begin
    int    count;     // consecutive request cycles
    int    exp_pend;  // pending_o right after the last request edge
    int    exp_len[9];
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive requests for one cycle; sample outputs at the following falling edge.
  task automatic tick(input bit c, input bit b);
    carry_i  = c;
    borrow_i = b;
    @(posedge clk_i);
    @(negedge clk_i);
    carry_i  = 1'b0;
    borrow_i = 1'b0;
  endtask

  // Entered right after a periodStart_o sample; runs nine whole periods.
  task automatic run_vec(input vec_t v);
    int ph;
    int high;
    int j;
    int guard;
    bit c;
    bit b;
    ph = 0;
    j = 0;
    guard = 0;
    high = clk_o ? 1 : 0;
    check({v.name, " adv p0"}, int'(advanced_o), (v.exp_len[0] == 15) ? 1 : 0);
    check({v.name, " ret p0"}, int'(retarded_o), (v.exp_len[0] == 17) ? 1 : 0);
    while (j < 9 && guard < 400) begin
      c = 1'b0;
      b = 1'b0;
      if (j == 0 && ph >= v.start && ph < v.start + v.count) begin
        c = v.carry;
        b = v.borrow;
      end
      tick(c, b);
      guard++;
      ph++;
      if (j == 0 && ph == v.start + v.count) begin
        check({v.name, " pending after requests"}, int'(pending_o), v.exp_pend);
      end
      if (periodStart_o) begin
        check($sformatf("%s len p%0d", v.name, j), ph, v.exp_len[j]);
        check($sformatf("%s high p%0d", v.name, j), high, 8);
        j++;
        if (j < 9) begin
          check($sformatf("%s adv p%0d", v.name, j), int'(advanced_o),
                (v.exp_len[j] == 15) ? 1 : 0);
          check($sformatf("%s ret p%0d", v.name, j), int'(retarded_o),
                (v.exp_len[j] == 17) ? 1 : 0);
        end
        ph = 0;
        high = clk_o ? 1 : 0;
      end else begin
        high += clk_o ? 1 : 0;
      end
    end
    if (guard >= 400) begin
      check({v.name, " period timeout"}, guard, 0);
    end
    check({v.name, " pending drained"}, int'(pending_o), 0);
  endtask

  initial begin
    vecs[0] = '{"idle", 1'b0, 1'b0, 1, 0, 0, '{16, 16, 16, 16, 16, 16, 16, 16, 16}};
    vecs[1] = '{"carry@5", 1'b1, 1'b0, 5, 1, 1, '{16, 15, 16, 16, 16, 16, 16, 16, 16}};
    vecs[2] = '{"borrow@15", 1'b0, 1'b1, 15, 1, -1, '{16, 16, 17, 16, 16, 16, 16, 16, 16}};
    vecs[3] = '{"both@3", 1'b1, 1'b1, 3, 1, 0, '{16, 16, 16, 16, 16, 16, 16, 16, 16}};
    vecs[4] = '{"carry x10", 1'b1, 1'b0, 2, 10, 7, '{16, 15, 15, 15, 15, 15, 15, 15, 16}};
    vecs[5] = '{"borrow x9", 1'b0, 1'b1, 2, 9, -7, '{16, 17, 17, 17, 17, 17, 17, 17, 16}};
    vecs[6] = '{"carry wide3", 1'b1, 1'b0, 4, 3, 3, '{16, 15, 15, 15, 16, 16, 16, 16, 16}};

    reset_i  = 1'b0;
    carry_i  = 1'b0;
    borrow_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset clk_o", int'(clk_o), 0);
    check("reset periodStart_o", int'(periodStart_o), 0);
    check("reset advanced_o", int'(advanced_o), 0);
    check("reset retarded_o", int'(retarded_o), 0);
    check("reset pending_o", int'(pending_o), 0);

    reset_i = 1'b1;
    tick(1'b0, 1'b0);
    check("first edge clk_o", int'(clk_o), 1);
    check("first edge periodStart_o", int'(periodStart_o), 1);
    check("first edge pending_o", int'(pending_o), 0);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
    end

    // Asynchronous reset in the middle of a period with two corrections outstanding.
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("midreset pre pending_o", int'(pending_o), 2);
    check("midreset pre clk_o", int'(clk_o), 1);
    #2;
    reset_i = 1'b0;
    #1;
    check("midreset async clk_o", int'(clk_o), 0);
    check("midreset async periodStart_o", int'(periodStart_o), 0);
    check("midreset async advanced_o", int'(advanced_o), 0);
    check("midreset async retarded_o", int'(retarded_o), 0);
    check("midreset async pending_o", int'(pending_o), 0);
    @(negedge clk_i);
    check("midreset held clk_o", int'(clk_o), 0);
    check("midreset held periodStart_o", int'(periodStart_o), 0);
    reset_i = 1'b1;
    tick(1'b0, 1'b0);
    check("midreset release clk_o", int'(clk_o), 1);
    check("midreset release periodStart_o", int'(periodStart_o), 1);
    check("midreset release pending_o", int'(pending_o), 0);
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
